// File: rtl/chaotic_sbox_generator.sv
// Builds a bijective 2^SBOX_W-entry S-box from NUM_CH chaotic sample streams, using linear probing over a used-value bitmap.
// Define SBOX_INVERSE_EN to add the inverse table and the inv_rd_data read port.
module chaotic_sbox_generator #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 3,
    parameter int SBOX_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable_bar,
    input  logic [NUM_CH*DATA_W-1:0] chaotic_signal,
    input  logic                     regen,
    input  logic [SBOX_W-1:0]        rd_addr,
    output logic [SBOX_W-1:0]        rd_data,
`ifdef SBOX_INVERSE_EN
    output logic [SBOX_W-1:0]        inv_rd_data,
`endif
    output logic                     ready,
    output logic [SBOX_W:0]          fill_count
);

    localparam int DEPTH = 1 << SBOX_W;
    localparam logic [SBOX_W:0] LAST_IDX = (SBOX_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, PROBE, DONE} state_t;

    state_t            state, state_nxt;
    logic [SBOX_W:0]   idx, idx_nxt;
    logic [SBOX_W-1:0] probe, probe_nxt;
    logic [DEPTH-1:0]  used;
    logic [SBOX_W-1:0] table_mem [DEPTH];
`ifdef SBOX_INVERSE_EN
    logic [SBOX_W-1:0] inv_mem [DEPTH];
`endif

    logic [SBOX_W-1:0] cand;
    logic [SBOX_W-1:0] wr_val;
    logic              wr_en;
    logic              clr_used;

    // Only the low SBOX_W bits of each channel feed the candidate.
    logic unused_upper_bits;
    assign unused_upper_bits = ^chaotic_signal;

    always_comb begin
        cand = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = cand ^ chaotic_signal[k*DATA_W +: SBOX_W];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        idx_nxt   = idx;
        probe_nxt = probe;
        wr_en     = 1'b0;
        wr_val    = cand;
        clr_used  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!enable_bar) begin
                    state_nxt = FILL;
                    idx_nxt   = '0;
                    clr_used  = 1'b1;
                end
            end
            FILL: begin
                if (!enable_bar) begin
                    if (!used[cand]) begin
                        wr_en  = 1'b1;
                        wr_val = cand;
                    end else begin
                        probe_nxt = cand + (SBOX_W)'(1);
                        state_nxt = PROBE;
                    end
                end
            end
            PROBE: begin
                if (!enable_bar) begin
                    if (!used[probe]) begin
                        wr_en     = 1'b1;
                        wr_val    = probe;
                        state_nxt = FILL;
                    end else begin
                        probe_nxt = probe + (SBOX_W)'(1);
                    end
                end
            end
            DONE: begin
                if (regen) begin
                    state_nxt = FILL;
                    idx_nxt   = '0;
                    clr_used  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The final write lands in DONE on the same edge, so ready rises with it.
        if (wr_en) begin
            idx_nxt = idx + (SBOX_W+1)'(1);
            if (idx == LAST_IDX) state_nxt = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            probe <= '0;
            used  <= '0;
            // NOTE: the tables are flop arrays that must read back as zero after reset, so they are reset explicitly.
            for (int a = 0; a < DEPTH; a++) begin
                table_mem[a] <= '0;
`ifdef SBOX_INVERSE_EN
                inv_mem[a]   <= '0;
`endif
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            idx   <= idx_nxt;
            probe <= probe_nxt;
            if (clr_used) begin
                used <= '0;
            end else if (wr_en) begin
                used[wr_val] <= 1'b1;
            end
            if (wr_en) begin
                table_mem[idx[SBOX_W-1:0]] <= wr_val;
`ifdef SBOX_INVERSE_EN
                inv_mem[wr_val]            <= idx[SBOX_W-1:0];
`endif
            end
        end
    end

    assign ready      = (state == DONE);
    assign fill_count = idx;
    assign rd_data    = ready ? table_mem[rd_addr] : '0;
`ifdef SBOX_INVERSE_EN
    assign inv_rd_data = ready ? inv_mem[rd_addr] : '0;
`endif

endmodule

// File: doc/chaotic_sbox_generator.md
# chaotic_sbox_generator

Parametrised successor to the fixed 16x16 substitution-box generator. It builds a bijective 2^SBOX_W-entry S-box from NUM_CH chaotic sample streams produced by the chaos generator. Each candidate is accepted or linear-probed using a used-value bitmap, which guarantees a permutation for any input sequence. The finished table is exposed through a read port instead of a flat array, and can be regenerated on request. It sits between the chaos generator and the substitution/cipher datapath.

## Interface
- DATA_W, 32, width of each chaotic sample channel
- NUM_CH, 3, number of chaotic channels folded per candidate (1..8)
- SBOX_W, 8, S-box entry width; table depth is 2^SBOX_W (2..8)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable_bar  in  1  active-low run enable; high stalls generation without consuming samples
- chaotic_signal  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- regen  in  1  single-cycle request to rebuild the table; honoured only in DONE
- rd_addr  in  SBOX_W  forward lookup address
- rd_data  out  SBOX_W  sbox[rd_addr]; 0 while ready=0
- inv_rd_data  out  SBOX_W  inverse lookup; present only with SBOX_INVERSE_EN
- ready  out  1  table complete and valid
- fill_count  out  SBOX_W+1  number of entries written so far

## Operation
- Candidate c = XOR over all channels of sample[SBOX_W-1:0].
- States: IDLE, FILL, PROBE, DONE. Reset enters IDLE.
- IDLE: when enable_bar=0, move to FILL with index i=0, used[] all 0.
- FILL, with enable_bar=0:
  - if used[c]=0: write table[i]=c, set used[c], increment i;
  - else latch probe=c+1 (mod 2^SBOX_W) and move to PROBE. No write that cycle.
- PROBE, with enable_bar=0: chaotic input is ignored.
  - if used[probe]=0: write table[i]=probe, set used, increment i, return to FILL;
  - else probe=probe+1 with wrap-around.
- After the write at i=2^SBOX_W-1, move to DONE. Exactly one free value remains for the final write, so termination is guaranteed.
- enable_bar=1 in FILL or PROBE: hold all registers, including i, probe and state.
- DONE: ready=1; table is frozen. regen=1 clears used[] and fill_count, sets i=0, deasserts ready, and enters FILL on the same edge. table contents are not cleared.
- regen outside DONE is ignored.
- Every table value is unique: table is a permutation of 0..2^SBOX_W-1.
- fill_count = i; it saturates at 2^SBOX_W in DONE.

## Timing
- Reset values: ready=0, fill_count=0, rd_data=0, inv_rd_data=0, state IDLE, table and used[] all 0.
- Reset asserted mid-fill aborts immediately and asynchronously. After deassertion, generation restarts from i=0 when enable_bar=0.
- The write is registered: an entry accepted at edge n is visible at edge n.
- Minimum latency: 2^SBOX_W enabled cycles from the first FILL cycle to the last write. ready rises on the edge of the final write (same edge as the transition to DONE).
- Worst case adds at most 2^SBOX_W-1 PROBE cycles per entry.
- rd_data and inv_rd_data are combinational from rd_addr, gated by ready.
- Simultaneous regen=1 and enable_bar=1 in DONE: regen is taken and FILL then stalls.

## Configuration
- SBOX_INVERSE_EN defined:
  - a second 2^SBOX_W x SBOX_W table is written inv[c]=i alongside every forward write;
  - it is cleared on reset;
  - inv_rd_data = inv[rd_addr] when ready, else 0.
- SBOX_INVERSE_EN undefined: no inverse storage and no inv_rd_data port.

## Test plan
- SBOX_W=4, NUM_CH=3, all channels constant 0x00000005:
  - required table 5,6,7,...,15,0,1,2,3,4;
  - ready rises after 16 writes, with 15 PROBE bursts in total;
  - fill_count=16.
- SBOX_W=8, chaos generator driving the inputs:
  - ready within 2^16 cycles;
  - all 256 rd_data values are distinct;
  - writes to ./output/substitution_box.txt.
- enable_bar held high for 20 cycles at fill_count=37: fill_count stays 37 and the table is unchanged; filling resumes when enable_bar returns low.
- Reset pulsed at fill_count=100: ready=0, fill_count=0 and rd_data=0 immediately; the rebuilt table matches a clean run with the same stimulus.
- regen pulse in DONE: ready=0 on the next edge and fill_count restarts at 0; regen pulsed during FILL has no effect.
- With SBOX_INVERSE_EN, for every a in 0..255: inv[sbox[a]]=a. Without the macro, the module compiles with no inv_rd_data port.
